clkdiv_ctrl: RTL and testbench
==============================

Name: clkdiv_ctrl

Overview:
Programmable clock-divider controller that sequences a divided clock waveform, clk_out, from the system clock. Software or a sequencer loads the period, high time and burst length through a valid/ready config port, then starts and stops the waveform. New configurations take effect only at period boundaries, so clk_out never glitches. Downstream blocks use clk_out, the per-period tick and done for stimulus and timing generation.

Parameters:
CNT_W, 16, width of the period, high-time, burst and period counters

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  start request; honoured only in IDLE
stop  in  1  stop request; honoured only in RUN
cfg_valid  in  1  config offer
cfg_ready  out  1  config slot free (= !pend_valid)
cfg_period  in  CNT_W  divided period in clk cycles
cfg_high  in  CNT_W  clk_out high cycles per period
cfg_burst  in  CNT_W  periods to emit; 0 = continuous
clk_out  out  1  divided clock, registered
tick  out  1  1-cycle pulse on the first cycle of each period
busy  out  1  state != IDLE
done  out  1  1-cycle pulse when the waveform terminates

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, clk_out=0, tick=0, done=0, busy=0, pend_valid=0 (cfg_ready=1), phase=0, pcount=0, active config period=2, high=1, burst=0. Reset overrides all other inputs, including in mid-run.
- Legalisation on acceptance: period<2 -> 2; high=0 -> 1; high>=period -> period-1 (using the legalised period).
- Config handshake: accepted on an edge with cfg_valid & cfg_ready, written to a one-entry pending register, pend_valid=1.
  - Pending is never applied on its own acceptance edge.
  - Applied (pend_valid cleared) at the next IDLE edge or the next period boundary, whichever comes first.
- States: IDLE, RUN, DRAIN. All outputs are registered.
- IDLE:
  - clk_out=0, tick=0.
  - start=1 & stop=0: state<=RUN, phase<=0, clk_out<=1, tick<=1, pcount<=1.
  - start & stop together: no action, stays IDLE.
  - stop alone is ignored.
  - If pending is valid on the start edge, it is applied first and the new config governs the first period.
- RUN/DRAIN, non-boundary edge (phase != period-1): phase<=phase+1, clk_out<=(phase+1 < high), tick<=0.
- RUN: stop=1 -> state<=DRAIN and the current period completes; start is ignored.
- Boundary edge (phase == period-1) terminates if state==DRAIN, or stop=1 this edge, or (burst!=0 & pcount>=burst):
  - Terminate: state<=IDLE, clk_out<=0, tick<=0, done<=1, phase<=0. Pending is left for the IDLE apply.
  - Otherwise: apply pending if valid, phase<=0, clk_out<=1, tick<=1, pcount<=pcount+1 (wraps).
- Lowering burst mid-run below pcount terminates at the next boundary (>= compare).
- done and tick are high for exactly one cycle. busy is the registered state != IDLE.
- Waveform: each period is high cycles of 1, then (period-high) cycles of 0. Latency from start edge to first clk_out=1 is the same edge (visible the next cycle).

Test Plan:
1. Reset, then start with the default config -> clk_out 1,0,1,0...; tick on every 1-cycle; busy=1; done never pulses; cfg_ready=1.
2. Config period=5, high=2, burst=3 in IDLE; start at edge k -> three periods of 11000, ticks at k, k+5, k+10; done at k+15; busy high for 15 cycles.
3. Run period=4, high=2, continuous; load period=6, high=3 at phase 1 -> cfg_ready=0 until the boundary; the current period finishes 1100, then 111000 repeats; cfg_ready returns to 1.
4. Config period=1, high=0 -> active period=2, high=1. Config period=4, high=7 -> high=3, waveform 1110.
5. Stop at phase 1 of period=8, high=4 -> the period finishes 11110000, done pulses, IDLE. Start and stop on the same IDLE edge -> stays IDLE, busy=0.
6. rst mid-run at phase 2 -> next cycle clk_out=0, busy=0, cfg_ready=1; a following start gives period 2, high 1.

Source files
------------

// File: rtl/clkdiv_ctrl.sv
// Programmable clock-divider controller: sequences a glitch-free divided clock
// with per-period tick, optional burst length and a one-entry config buffer.
module clkdiv_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_burst,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, pcount_q;
    logic [CNT_W-1:0] per_q, high_q, burst_q;
    logic             pend_valid_q;
    logic [CNT_W-1:0] pend_per_q, pend_high_q, pend_burst_q;
    logic             clk_out_q, tick_q, done_q, busy_q;

    logic             boundary, restart, term, apply, accept;
    logic             clk_out_d, tick_d, done_d, busy_d;
    logic [CNT_W-1:0] legal_per, legal_high;

    function automatic logic [CNT_W-1:0] legalise_period(input logic [CNT_W-1:0] p);
        return (p < TWO) ? TWO : p;
    endfunction

    // High time is clamped against the already-legalised period.
    function automatic logic [CNT_W-1:0] legalise_high(input logic [CNT_W-1:0] h,
                                                       input logic [CNT_W-1:0] p);
        logic [CNT_W-1:0] hh;
        hh = (h == '0) ? ONE : h;
        return (hh >= p) ? (p - ONE) : hh;
    endfunction

    assign legal_per  = legalise_period(cfg_period);
    assign legal_high = legalise_high(cfg_high, legal_per);
    assign accept     = cfg_valid && !pend_valid_q;
    assign boundary   = (phase_q == per_q - ONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; restart marks the first cycle of a new period
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        term    = 1'b0;
        apply   = 1'b0;
        case (state_q)
            IDLE: begin
                apply = pend_valid_q;
                if (start && !stop) begin
                    state_d = RUN;
                    restart = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (boundary) begin
                    if (state_q == DRAIN || stop ||
                        (burst_q != '0 && pcount_q >= burst_q)) begin
                        term    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        restart = 1'b1;
                        apply   = pend_valid_q;
                    end
                end else if (state_q == RUN && stop) begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic, registered below
    always_comb begin
        clk_out_d = 1'b0;
        if (restart)
            clk_out_d = 1'b1;
        else if (state_q != IDLE && !boundary)
            clk_out_d = (phase_q + ONE) < high_q;
        tick_d = restart;
        done_d = term;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            phase_q      <= '0;
            pcount_q     <= '0;
            per_q        <= TWO;
            high_q       <= ONE;
            burst_q      <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            if (restart || term)
                phase_q <= '0;
            else if (state_q != IDLE)
                phase_q <= phase_q + ONE;
            if (restart)
                pcount_q <= (state_q == IDLE) ? ONE : pcount_q + ONE;
            if (apply) begin
                per_q        <= pend_per_q;
                high_q       <= pend_high_q;
                burst_q      <= pend_burst_q;
                pend_valid_q <= 1'b0;
            end else if (accept) begin
                pend_valid_q <= 1'b1;
            end
        end
    end

    // Pending payload is only meaningful while pend_valid_q is set
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_per_q   <= legal_per;
            pend_high_q  <= legal_high;
            pend_burst_q <= cfg_burst;
        end
    end

    assign cfg_ready = !pend_valid_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Bench for clkdiv_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a period/position model of the waveform.
module tb_clkdiv_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, start, stop, cfg_valid;
    logic             cfg_ready, clk_out, tick, busy, done;
    logic [CNT_W-1:0] cfg_period, cfg_high, cfg_burst;

    int n_tests = 0;
    int n_fail  = 0;

    clkdiv_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_burst(cfg_burst),
        .clk_out(clk_out), .tick(tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model: running flag, position within the current period, periods emitted
    int m_run, m_drain, m_pos, m_cnt, m_done;
    int a_per, a_hi, a_bur;
    int p_valid, p_per, p_hi, p_bur;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_drain = 0; m_pos = 0; m_cnt = 0; m_done = 0;
        a_per = 2; a_hi = 1; a_bur = 0; p_valid = 0;
    endfunction

    function automatic void model_apply();
        a_per = p_per; a_hi = p_hi; a_bur = p_bur; p_valid = 0;
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit sp,
                                       input bit cv, input int cp, input int ch,
                                       input int cb);
        int lp, lh;
        bit acc;
        if (r) begin
            model_reset();
            return;
        end
        acc = cv && (p_valid == 0);
        lp = (cp < 2) ? 2 : cp;
        lh = (ch == 0) ? 1 : ch;
        if (lh >= lp) lh = lp - 1;
        m_done = 0;
        if (m_run == 0) begin
            if (p_valid != 0) model_apply();
            if (s && !sp) begin
                m_run = 1; m_drain = 0; m_pos = 0; m_cnt = 1;
            end
        end else if (m_pos == a_per - 1) begin
            if (m_drain != 0 || sp || (a_bur != 0 && m_cnt >= a_bur)) begin
                m_run = 0; m_drain = 0; m_done = 1; m_pos = 0;
            end else begin
                if (p_valid != 0) model_apply();
                m_pos = 0;
                m_cnt = (m_cnt + 1) % 65536;
            end
        end else begin
            m_pos++;
            if (sp) m_drain = 1;
        end
        if (acc) begin
            p_valid = 1; p_per = lp; p_hi = lh; p_bur = cb;
        end
    endfunction

    // One clock: drive, advance model at the edge, check 1 time unit later
    task automatic cyc(input bit r, input bit s, input bit sp, input bit cv,
                       input int cp = 0, input int ch = 0, input int cb = 0);
        rst = r; start = s; stop = sp; cfg_valid = cv;
        cfg_period = cp[CNT_W-1:0]; cfg_high = ch[CNT_W-1:0]; cfg_burst = cb[CNT_W-1:0];
        @(posedge clk);
        model_step(r, s, sp, cv, cp, ch, cb);
        #1;
        chk("clk_out",   int'(clk_out),   (m_run != 0 && m_pos < a_hi) ? 1 : 0);
        chk("tick",      int'(tick),      (m_run != 0 && m_pos == 0) ? 1 : 0);
        chk("busy",      int'(busy),      m_run);
        chk("done",      int'(done),      m_done);
        chk("cfg_ready", int'(cfg_ready), (p_valid == 0) ? 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        int ticks, busyc, dones;
        logic [3:0] wave;
        model_reset();

        // Reset state, then default config waveform 1010...
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 1, 5, 2, 1);
        cyc(0, 1, 0, 0);
        idle(9);
        cyc(0, 0, 1, 0);
        idle(3);

        // period 5, high 2, burst 3: three ticks, busy for 15 cycles, one done
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1, 5, 2, 3);
        idle(1);
        ticks = 0; busyc = 0; dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) cyc(0, 1, 0, 0); else idle(1);
            ticks += int'(tick); busyc += int'(busy); dones += int'(done);
        end
        chk("burst_ticks", ticks, 3);
        chk("burst_busy",  busyc, 15);
        chk("burst_done",  dones, 1);

        // Reconfigure mid-period: 4/2 continuous, then load 6/3 at phase 1
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1, 4, 2, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1, 6, 3, 0);
        idle(14);
        cyc(0, 0, 1, 0);
        idle(6);

        // Legalisation: 1/0 -> 2/1, then 4/7 -> 4/3 giving 1110
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        idle(4);
        cyc(0, 0, 1, 0);
        idle(2);
        cyc(0, 0, 0, 1, 4, 7, 0);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) cyc(0, 1, 0, 0); else idle(1);
            wave[3-i] = clk_out;
        end
        chk("legal_wave", int'(wave), int'(4'b1110));
        cyc(0, 0, 1, 0);
        idle(2);

        // Stop at phase 1 of 8/4, then start+stop together in IDLE
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1, 8, 4, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        idle(8);
        cyc(0, 1, 1, 0);
        idle(2);

        // Reset at phase 2 of a run, then restart with defaults
        cyc(0, 0, 0, 1, 6, 3, 0);
        cyc(0, 1, 0, 0);
        idle(2);
        cyc(1, 0, 0, 1, 7, 2, 0);
        cyc(0, 1, 0, 0);
        idle(5);

        // Random traffic
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            int hv;
            hv = ($urandom % 12 == 0) ? 65535 : int'($urandom_range(0, 11));
            cyc(($urandom % 400) == 0, ($urandom % 6) == 0, ($urandom % 14) == 0,
                ($urandom % 4) == 0, int'($urandom_range(0, 9)), hv,
                int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
